// File: rtl/irq_pkg.sv
// Purpose: shared types and helpers for the interrupt controller and its encoder.
// Latency: none, declarations only.
// Backpressure: not applicable.
package irq_pkg;

  localparam int IRQ_NSRC_MAX = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  function automatic int vec_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Purpose: lowest-index-first priority encoder (index 0 wins).
// Latency: purely combinational.
// Backpressure: not applicable.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int VW   = vec_width(NSRC)
) (
  input  logic [NSRC-1:0] req,
  output logic [VW-1:0]   idx,
  output logic            vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Scan downwards so the last assignment is the lowest set index.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Purpose: collects event pulses into pending bits, masks/prioritises, delivers one irq at a time (IRQ_OVERFLOW_EN adds sticky lost-event flags).
// Latency: pending visible 1 cycle after a pulse, irq asserted 1 cycle after eligible goes nonzero.
// Backpressure: the CPU paces delivery via irq_ack/irq_done; new events merge into pending meanwhile.
module irq_controller
  import irq_pkg::*;
#(
  parameter int              NSRC     = 4,
  parameter int              VW       = vec_width(NSRC),
  parameter logic [NSRC-1:0] MASK_RST = '1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_pulse,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] pending,
  output logic            irq,
  input  logic            irq_ack,
  output logic [VW-1:0]   irq_vec,
  output logic            in_service,
  input  logic            irq_done
`ifdef IRQ_OVERFLOW_EN
  ,
  output logic [NSRC-1:0] overflow,
  input  logic [NSRC-1:0] ovf_clr
`endif
);

  irq_state_e      state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            irq_q, irq_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            insvc_q, insvc_d;

  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr;
  logic [VW-1:0]   win_idx;
  logic            win_vld;

  assign eligible = pending_q & mask_q;

  irq_prio_enc #(
    .NSRC (NSRC),
    .VW   (VW)
  ) u_prio_enc (
    .req (eligible),
    .idx (win_idx),
    .vld (win_vld)
  );

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    insvc_d = insvc_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = REQ;
          irq_d   = 1'b1;
        end
      end
      REQ: begin
        if (!win_vld) begin
          // Request withdrawn by a mask write; nothing is latched.
          state_d = IDLE;
          irq_d   = 1'b0;
        end else if (irq_ack) begin
          state_d = SERVICE;
          irq_d   = 1'b0;
          insvc_d = 1'b1;
          vec_d   = win_idx;
          clr     = NSRC'(1) << win_idx;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          state_d = IDLE;
          insvc_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
        insvc_d = 1'b0;
      end
    endcase
  end

  // A pulse on the bit being cleared keeps it pending.
  assign pending_d = (pending_q & ~clr) | src_pulse;
  assign mask_d    = mask_we ? mask_wdata : mask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      irq_q     <= 1'b0;
      vec_q     <= '0;
      insvc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
      vec_q     <= vec_d;
      insvc_q   <= insvc_d;
    end
  end

  assign mask       = mask_q;
  assign pending    = pending_q;
  assign irq        = irq_q;
  assign irq_vec    = vec_q;
  assign in_service = insvc_q;

`ifdef IRQ_OVERFLOW_EN
  logic [NSRC-1:0] ovf_q, ovf_d;

  // A new event on a bit still pending (and not being serviced now) is a lost event.
  assign ovf_d = (ovf_q & ~ovf_clr) | (src_pulse & pending_q & ~clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Purpose: scoreboard bench for irq_controller; expected vectors queued at stimulus, popped at acknowledge.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: every wait on irq is bounded and a timeout counts as a failure.
module tb_irq_controller;

  logic       clk;
  logic       reset;
  logic [3:0] src_pulse;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] mask;
  logic [3:0] pending;
  logic       irq;
  logic       irq_ack;
  logic [1:0] irq_vec;
  logic       in_service;
  logic       irq_done;
`ifdef IRQ_OVERFLOW_EN
  logic [3:0] overflow;
  logic [3:0] ovf_clr;
`endif

  int total = 0;
  int bad   = 0;
  int sb[$];
  int exp_vec;

  irq_controller #(.NSRC(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_pulse  (src_pulse),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .irq_vec    (irq_vec),
    .in_service (in_service),
    .irq_done   (irq_done)
`ifdef IRQ_OVERFLOW_EN
    ,
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (irq) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; src_pulse = '0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; irq_done = 1'b0;
`ifdef IRQ_OVERFLOW_EN
    ovf_clr = '0;
`endif
    #12;
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    total++; if (mask !== 4'b1111) begin bad++; $display("FAIL reset_mask got=%b exp=1111", mask); end
    total++; if ({irq, in_service, irq_vec} !== 4'b0000) begin bad++; $display("FAIL reset_ctl got irq=%b svc=%b vec=%0d exp 0/0/0", irq, in_service, irq_vec); end
    @(negedge clk); reset = 1'b1;
    tick();
    // Acknowledge with nothing pending must be ignored.
    do_ack();
    tick();
    total++; if ({irq, in_service} !== 2'b00) begin bad++; $display("FAIL idle_ack got irq=%b svc=%b exp 0/0", irq, in_service); end
  endtask

  task automatic test_basic();
    bit ok;
    src_pulse = 4'b0100; sb.push_back(2);
    tick();
    src_pulse = '0;
    total++; if (pending !== 4'b0100) begin bad++; $display("FAIL basic_pending got=%b exp=0100", pending); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_early got=%b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq got=%b exp=1", irq); end
    wait_irq(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_wait got=timeout exp=irq"); end
    do_ack();
    exp_vec = sb.pop_front();
    total++; if (int'(irq_vec) != exp_vec) begin bad++; $display("FAIL basic_vec got=%0d exp=%0d", irq_vec, exp_vec); end
    total++; if ({pending, irq, in_service} !== 6'b0000_01) begin bad++; $display("FAIL basic_svc got pend=%b irq=%b svc=%b exp 0000/0/1", pending, irq, in_service); end
    do_ack();  // ignored while in service
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL basic_ack_in_svc got=%b exp=1", in_service); end
    do_done();
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL basic_done got=%b exp=0", in_service); end
    tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_quiet got=%b exp=0", irq); end
  endtask

  task automatic test_priority();
    bit ok;
    src_pulse = 4'b1010; sb.push_back(1); sb.push_back(3);
    tick();
    src_pulse = '0;
    wait_irq(ok);
    total++; if (!ok) begin bad++; $display("FAIL prio_wait1 got=timeout exp=irq"); end
    do_ack();
    exp_vec = sb.pop_front();
    total++; if (int'(irq_vec) != exp_vec) begin bad++; $display("FAIL prio_vec1 got=%0d exp=%0d", irq_vec, exp_vec); end
    total++; if (pending !== 4'b1000) begin bad++; $display("FAIL prio_pend got=%b exp=1000", pending); end
    do_done();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL prio_gap got=%b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL prio_reassert got=%b exp=1", irq); end
    wait_irq(ok);
    do_ack();
    exp_vec = sb.pop_front();
    total++; if (int'(irq_vec) != exp_vec) begin bad++; $display("FAIL prio_vec2 got=%0d exp=%0d", irq_vec, exp_vec); end
    do_done();
  endtask

  task automatic test_mask_and_withdraw();
    bit ok;
    mask_we = 1'b1; mask_wdata = 4'b1110;
    tick();
    mask_we = 1'b0;
    total++; if (mask !== 4'b1110) begin bad++; $display("FAIL mask_write got=%b exp=1110", mask); end
    src_pulse = 4'b0001;
    tick();
    src_pulse = '0;
    total++; if (pending !== 4'b0001) begin bad++; $display("FAIL mask_pend got=%b exp=0001", pending); end
    tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_blocked got=%b exp=0", irq); end
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL unmask_early got=%b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL unmask_irq got=%b exp=1", irq); end
    // Withdraw the pending request by masking everything while in REQ.
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    tick();
    total++; if ({irq, in_service} !== 2'b00) begin bad++; $display("FAIL withdraw_ctl got irq=%b svc=%b exp 0/0", irq, in_service); end
    total++; if (pending !== 4'b0001) begin bad++; $display("FAIL withdraw_pend got=%b exp=0001", pending); end
    total++; if (irq_vec !== 2'd3) begin bad++; $display("FAIL withdraw_vec got=%0d exp=3", irq_vec); end
    mask_we = 1'b1; mask_wdata = 4'b1111; sb.push_back(0);
    tick();
    mask_we = 1'b0;
    wait_irq(ok);
    total++; if (!ok) begin bad++; $display("FAIL remask_wait got=timeout exp=irq"); end
    do_ack();
    exp_vec = sb.pop_front();
    total++; if (int'(irq_vec) != exp_vec) begin bad++; $display("FAIL remask_vec got=%0d exp=%0d", irq_vec, exp_vec); end
    do_done();
  endtask

  task automatic test_set_beats_clear();
    bit ok;
    src_pulse = 4'b0001; sb.push_back(0);
    tick();
    src_pulse = '0;
    wait_irq(ok);
    total++; if (!ok) begin bad++; $display("FAIL sbc_wait got=timeout exp=irq"); end
    src_pulse = 4'b0001; sb.push_back(0);
    do_ack();
    src_pulse = '0;
    exp_vec = sb.pop_front();
    total++; if (int'(irq_vec) != exp_vec) begin bad++; $display("FAIL sbc_vec got=%0d exp=%0d", irq_vec, exp_vec); end
    total++; if (pending !== 4'b0001) begin bad++; $display("FAIL sbc_pend got=%b exp=0001", pending); end
    do_done();
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL sbc_reassert got=%b exp=1", irq); end
    do_ack();
    exp_vec = sb.pop_front();
    total++; if (int'(irq_vec) != exp_vec || pending !== 4'b0000) begin bad++; $display("FAIL sbc_vec2 got vec=%0d pend=%b exp %0d/0000", irq_vec, pending, exp_vec); end
    do_done();
  endtask

  task automatic test_overflow_and_reset();
    bit ok;
`ifdef IRQ_OVERFLOW_EN
    src_pulse = 4'b0010;
    tick();
    tick();
    src_pulse = '0;
    total++; if (overflow !== 4'b0010) begin bad++; $display("FAIL ovf_set got=%b exp=0010", overflow); end
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = '0;
    total++; if (overflow !== 4'b0000) begin bad++; $display("FAIL ovf_clr got=%b exp=0000", overflow); end
`else
    src_pulse = 4'b0010;
    tick();
    src_pulse = '0;
`endif
    sb.push_back(1);
    wait_irq(ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_wait got=timeout exp=irq"); end
    mask_we = 1'b1; mask_wdata = 4'b0101;
    src_pulse = 4'b1000;
    do_ack();
    mask_we = 1'b0; src_pulse = '0;
    exp_vec = sb.pop_front();
    total++; if (int'(irq_vec) != exp_vec || in_service !== 1'b1) begin bad++; $display("FAIL rst_pre_vec got vec=%0d svc=%b exp %0d/1", irq_vec, in_service, exp_vec); end
    #2 reset = 1'b0;
    #1;
    total++; if ({pending, mask} !== 8'b0000_1111) begin bad++; $display("FAIL async_rst_regs got pend=%b mask=%b exp 0000/1111", pending, mask); end
    total++; if ({irq, in_service, irq_vec} !== 4'b0000) begin bad++; $display("FAIL async_rst_ctl got irq=%b svc=%b vec=%0d exp 0/0/0", irq, in_service, irq_vec); end
`ifdef IRQ_OVERFLOW_EN
    total++; if (overflow !== 4'b0000) begin bad++; $display("FAIL async_rst_ovf got=%b exp=0000", overflow); end
`endif
    @(negedge clk); reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask_and_withdraw();
    test_set_beats_clear();
    test_overflow_and_reset();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
